// File: rtl/qk_pkg.sv
// Shared state encoding and width helper for the streaming QK score engine.
package qk_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_ROW = 3'd1,
      MAC      = 3'd2,
      EMIT     = 3'd3,
      DONE     = 3'd4
   } qk_state_e;

   // Full-precision width: one DW x DW product plus one carry bit per doubling of terms.
   function automatic int acc_width(input int dw, input int head_dim);
      return 2 * dw + $clog2(head_dim);
   endfunction

endpackage

// File: rtl/qk_mac_lanes.sv
// Combinational LANES-wide signed multiply and reduction, sign-extended to ACC_W.
module qk_mac_lanes
   import qk_pkg::*;
#(
   parameter int DW    = 4,
   parameter int LANES = 1,
   parameter int ACC_W = 10
)(
   input  logic [LANES*DW-1:0]     q_i,
   input  logic [LANES*DW-1:0]     k_i,
   output logic signed [ACC_W-1:0] psum_o
);

   logic signed [DW-1:0]   q_e;
   logic signed [DW-1:0]   k_e;
   logic signed [2*DW-1:0] prod;

   // NOTE: every variable assigned in this block gets a default first, so no path leaves a latch.
   always_comb begin
      psum_o = '0;
      q_e    = '0;
      k_e    = '0;
      prod   = '0;
      for (int l = 0; l < LANES; l++) begin
         q_e    = q_i[l*DW +: DW];
         k_e    = k_i[l*DW +: DW];
         prod   = (2*DW)'(q_e) * (2*DW)'(k_e);
         psum_o = psum_o + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/qk_score_engine.sv
// Streaming QK dot-product engine: latch one query, score SEQ_LEN key rows.
// Optional `define QK_SCALE_SHIFT_EN adds SCALE_SHIFT round-half-up scaling of each score.
module qk_score_engine
   import qk_pkg::*;
#(
   parameter int HEAD_DIM = 4,
   parameter int SEQ_LEN  = 3,
   parameter int DW       = 4,
   parameter int LANES    = 1,
`ifdef QK_SCALE_SHIFT_EN
   parameter int SCALE_SHIFT = 1,
`endif
   localparam int ACC_W = acc_width(DW, HEAD_DIM),
   localparam int IDX_W = $clog2(SEQ_LEN) + 1
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [HEAD_DIM*DW-1:0] q_vec,
   input  logic                   k_valid,
   output logic                   k_ready,
   input  logic [HEAD_DIM*DW-1:0] k_row,
   output logic                   s_valid,
   input  logic                   s_ready,
   output logic [ACC_W-1:0]       score,
   output logic [IDX_W-1:0]       s_idx,
   output logic                   busy,
   output logic                   done
);

   localparam int BEATS  = HEAD_DIM / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int GW     = LANES * DW;

   if ((HEAD_DIM % LANES) != 0) begin : g_bad_lanes
      $error("qk_score_engine: HEAD_DIM must be a multiple of LANES");
   end
   if (SEQ_LEN < 1) begin : g_bad_seq
      $error("qk_score_engine: SEQ_LEN must be at least 1");
   end

   qk_state_e               state_q, state_d;
   logic                    armed_q;
   logic [HEAD_DIM*DW-1:0]  q_q, q_d;
   logic [HEAD_DIM*DW-1:0]  k_q, k_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [IDX_W-1:0]        row_q, row_d;
   logic signed [ACC_W-1:0] score_q, score_d;
   logic [IDX_W-1:0]        sidx_q, sidx_d;

   logic [GW-1:0]           q_lanes;
   logic [GW-1:0]           k_lanes;
   logic signed [ACC_W-1:0] psum;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] acc_final;

   assign q_lanes = q_q[beat_q*GW +: GW];
   assign k_lanes = k_q[beat_q*GW +: GW];

   qk_mac_lanes #(
      .DW    (DW),
      .LANES (LANES),
      .ACC_W (ACC_W)
   ) u_mac_lanes (
      .q_i    (q_lanes),
      .k_i    (k_lanes),
      .psum_o (psum)
   );

   assign acc_sum = acc_q + psum;

`ifdef QK_SCALE_SHIFT_EN
   localparam logic signed [ACC_W-1:0] ROUND_ADD = ACC_W'(1 << (SCALE_SHIFT - 1));
   assign acc_final = (acc_sum + ROUND_ADD) >>> SCALE_SHIFT;
`else
   assign acc_final = acc_sum;
`endif

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      k_d     = k_q;
      acc_d   = acc_q;
      beat_d  = beat_q;
      row_d   = row_q;
      score_d = score_q;
      sidx_d  = sidx_q;
      unique case (state_q)
         IDLE: begin
            if (start && armed_q) begin
               q_d     = q_vec;
               row_d   = '0;
               state_d = WAIT_ROW;
            end
         end
         WAIT_ROW: begin
            if (k_valid) begin
               k_d     = k_row;
               acc_d   = '0;
               beat_d  = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            if (beat_q == BEAT_W'(BEATS - 1)) begin
               score_d = acc_final;
               sidx_d  = row_q;
               state_d = EMIT;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         EMIT: begin
            if (s_ready) begin
               if (row_q == IDX_W'(SEQ_LEN - 1)) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = WAIT_ROW;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
         q_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         beat_q  <= '0;
         row_q   <= '0;
         score_q <= '0;
         sidx_q  <= '0;
      end else begin
         state_q <= state_d;
         // Keeps a start coincident with reset release from being taken.
         armed_q <= 1'b1;
         q_q     <= q_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         beat_q  <= beat_d;
         row_q   <= row_d;
         score_q <= score_d;
         sidx_q  <= sidx_d;
      end
   end

   assign k_ready = (state_q == WAIT_ROW);
   assign s_valid = (state_q == EMIT);
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign score   = score_q;
   assign s_idx   = sidx_q;

endmodule

// File: tb/tb_qk_score_engine.sv
// Table-driven plus randomized bench for qk_score_engine at LANES = 1, 2 and 4 side by side.
module tb_qk_score_engine;

   localparam int HEAD_DIM = 4;
   localparam int SEQ_LEN  = 3;
   localparam int DW       = 4;
   localparam int NDUT     = 3;
   localparam int ACC_W    = 2 * DW + $clog2(HEAD_DIM);
   localparam int IDX_W    = $clog2(SEQ_LEN) + 1;
   localparam int VW       = HEAD_DIM * DW;
   localparam int LIMIT    = 64;
`ifdef QK_SCALE_SHIFT_EN
   localparam int SCALE_SHIFT = 1;
`endif

   typedef struct packed {
      logic [VW-1:0]                 q;
      logic [SEQ_LEN-1:0][VW-1:0]    rows;
      logic [SEQ_LEN-1:0][31:0]      exp;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             start_a   [NDUT];
   logic [VW-1:0]    q_vec_a   [NDUT];
   logic             k_valid_a [NDUT];
   logic             k_ready_a [NDUT];
   logic [VW-1:0]    k_row_a   [NDUT];
   logic             s_valid_a [NDUT];
   logic             s_ready_a [NDUT];
   logic [ACC_W-1:0] score_a   [NDUT];
   logic [IDX_W-1:0] s_idx_a   [NDUT];
   logic             busy_a    [NDUT];
   logic             done_a    [NDUT];

   int n_vec;
   int n_err;
   int done_cnt [NDUT];
   vec_t tbl [$];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      qk_score_engine #(
         .HEAD_DIM (HEAD_DIM),
         .SEQ_LEN  (SEQ_LEN),
         .DW       (DW),
         .LANES    (1 << g)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .start   (start_a[g]),
         .q_vec   (q_vec_a[g]),
         .k_valid (k_valid_a[g]),
         .k_ready (k_ready_a[g]),
         .k_row   (k_row_a[g]),
         .s_valid (s_valid_a[g]),
         .s_ready (s_ready_a[g]),
         .score   (score_a[g]),
         .s_idx   (s_idx_a[g]),
         .busy    (busy_a[g]),
         .done    (done_a[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (done_a[d]) done_cnt[d]++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] pack(input int e0, input int e1, input int e2, input int e3);
      logic [VW-1:0] v;
      v[0*DW +: DW] = DW'(e0);
      v[1*DW +: DW] = DW'(e1);
      v[2*DW +: DW] = DW'(e2);
      v[3*DW +: DW] = DW'(e3);
      return v;
   endfunction

   function automatic vec_t mk(input logic [VW-1:0] q, input logic [VW-1:0] r0,
                               input logic [VW-1:0] r1, input logic [VW-1:0] r2,
                               input int e0, input int e1, input int e2);
      vec_t v;
      v.q       = q;
      v.rows[0] = r0;
      v.rows[1] = r1;
      v.rows[2] = r2;
      v.exp[0]  = e0;
      v.exp[1]  = e1;
      v.exp[2]  = e2;
      return v;
   endfunction

   // Reference: plain integer dot product, then optional round-half-up scaling.
   function automatic int model_score(input logic [VW-1:0] q, input logic [VW-1:0] k);
      int s;
      s = 0;
      for (int i = 0; i < HEAD_DIM; i++) begin
         s += int'($signed(q[i*DW +: DW])) * int'($signed(k[i*DW +: DW]));
      end
`ifdef QK_SCALE_SHIFT_EN
      s = (s + (1 << (SCALE_SHIFT - 1))) >>> SCALE_SHIFT;
`endif
      return s;
   endfunction

   function automatic int rnd_elem();
      return int'($urandom_range(15)) - 8;
   endfunction

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("%s k_ready d%0d", tag, d), k_ready_a[d], 0);
         check($sformatf("%s s_valid d%0d", tag, d), s_valid_a[d], 0);
         check($sformatf("%s busy d%0d", tag, d), busy_a[d], 0);
         check($sformatf("%s done d%0d", tag, d), done_a[d], 0);
         check($sformatf("%s score d%0d", tag, d), score_a[d], 0);
         check($sformatf("%s s_idx d%0d", tag, d), s_idx_a[d], 0);
      end
   endtask

   // One full query: start, SEQ_LEN rows, scores, done pulse.
   task automatic run_job(input int d, input vec_t v, input int bp_row, input int bp_cyc,
                          input bit hold_kv, input bit glitch);
      int n;
      int lat;
      int dc0;
      int nb;
      nb  = HEAD_DIM / (1 << d);
      dc0 = done_cnt[d];
      @(negedge clk);
      check($sformatf("idle d%0d", d), busy_a[d], 0);
      start_a[d] = 1'b1;
      q_vec_a[d] = v.q;
      @(negedge clk);
      start_a[d] = 1'b0;
      q_vec_a[d] = pack(-7, -7, -7, -7);
      check($sformatf("busy after start d%0d", d), busy_a[d], 1);
      for (int r = 0; r < SEQ_LEN; r++) begin
         k_row_a[d]   = v.rows[r];
         k_valid_a[d] = 1'b1;
         s_ready_a[d] = (r == bp_row && bp_cyc > 0) ? 1'b0 : 1'b1;
         n = 0;
         while (!k_ready_a[d] && n < LIMIT) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("k_ready wait d%0d r%0d", d, r), (n < LIMIT), 1);
         @(negedge clk);
         lat = 1;
         if (!hold_kv) k_valid_a[d] = 1'b0;
         k_row_a[d] = ~v.rows[r];
         check($sformatf("k_ready drop d%0d r%0d", d, r), k_ready_a[d], 0);
         while (!s_valid_a[d] && lat < LIMIT) begin
            if (glitch && r == 1 && lat == 1) begin
               start_a[d] = 1'b1;
               q_vec_a[d] = pack(7, 7, 7, 7);
            end else begin
               start_a[d] = 1'b0;
            end
            @(negedge clk);
            lat++;
         end
         start_a[d] = 1'b0;
         check($sformatf("latency d%0d r%0d", d, r), lat, nb + 1);
         check($sformatf("score d%0d r%0d", d, r), int'($signed(score_a[d])), int'(v.exp[r]));
         check($sformatf("s_idx d%0d r%0d", d, r), s_idx_a[d], r);
         if (!s_ready_a[d]) begin
            for (int c = 0; c < bp_cyc; c++) begin
               @(negedge clk);
               check($sformatf("bp s_valid d%0d c%0d", d, c), s_valid_a[d], 1);
               check($sformatf("bp score d%0d c%0d", d, c), int'($signed(score_a[d])), int'(v.exp[r]));
               check($sformatf("bp k_ready d%0d c%0d", d, c), k_ready_a[d], 0);
            end
            s_ready_a[d] = 1'b1;
         end
         @(negedge clk);
      end
      check($sformatf("done pulse d%0d", d), done_a[d], 1);
      check($sformatf("busy in done d%0d", d), busy_a[d], 1);
      @(negedge clk);
      check($sformatf("done clear d%0d", d), done_a[d], 0);
      check($sformatf("busy clear d%0d", d), busy_a[d], 0);
      if (hold_kv) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("no extra row d%0d c%0d", d, c), k_ready_a[d] | busy_a[d], 0);
         end
         k_valid_a[d] = 1'b0;
      end
      check($sformatf("done count d%0d", d), done_cnt[d] - dc0, 1);
   endtask

   initial begin
      int n;
      int dc_before;
      logic [VW-1:0] rq;
      logic [VW-1:0] rr [SEQ_LEN];
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         start_a[d]   = 1'b0;
         q_vec_a[d]   = '0;
         k_valid_a[d] = 1'b0;
         k_row_a[d]   = '0;
         s_ready_a[d] = 1'b1;
      end
      #1;
      check_reset_outputs("reset");

`ifdef QK_SCALE_SHIFT_EN
      tbl.push_back(mk(pack(1, 2, 3, 4), pack(1, 0, 1, 0), pack(0, 1, 0, 1), pack(1, 1, 1, 1), 2, 3, 5));
      tbl.push_back(mk(pack(-8, -8, -8, -8), pack(-8, -8, -8, -8), pack(7, 7, 7, 7), pack(7, -8, 7, -8), 128, -112, 8));
      tbl.push_back(mk(pack(1, 2, 3, 4), pack(0, 0, 1, 1), pack(-1, -1, 0, 0), pack(0, 0, 0, 0), 4, -1, 0));
      tbl.push_back(mk(pack(7, 7, 7, 7), pack(7, 7, 7, 7), pack(-8, -8, -8, -8), pack(7, -8, 0, 1), 98, -112, 0));
`else
      tbl.push_back(mk(pack(1, 2, 3, 4), pack(1, 0, 1, 0), pack(0, 1, 0, 1), pack(1, 1, 1, 1), 4, 6, 10));
      tbl.push_back(mk(pack(-8, -8, -8, -8), pack(-8, -8, -8, -8), pack(7, 7, 7, 7), pack(7, -8, 7, -8), 256, -224, 16));
      tbl.push_back(mk(pack(1, 2, 3, 4), pack(0, 0, 1, 1), pack(-1, -1, 0, 0), pack(0, 0, 0, 0), 7, -3, 0));
      tbl.push_back(mk(pack(7, 7, 7, 7), pack(7, 7, 7, 7), pack(-8, -8, -8, -8), pack(7, -8, 0, 1), 196, -224, 0));
`endif
      for (int i = 0; i < 8; i++) begin
         rq = pack(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem());
         for (int r = 0; r < SEQ_LEN; r++) rr[r] = pack(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem());
         tbl.push_back(mk(rq, rr[0], rr[1], rr[2],
                          model_score(rq, rr[0]), model_score(rq, rr[1]), model_score(rq, rr[2])));
      end

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         int bpc;
         bpc = (i >= 4) ? int'($urandom_range(3)) : 0;
         for (int d = 0; d < NDUT; d++) begin
            run_job(d, tbl[i], (i >= 4) ? (i % SEQ_LEN) : -1, bpc, 1'b0, 1'b0);
         end
      end

      // Backpressure on row 1 for seven cycles.
      run_job(0, tbl[0], 1, 7, 1'b0, 1'b0);

      // Start pulsed while busy, k_valid held high across all rows.
      for (int d = 0; d < NDUT; d++) run_job(d, tbl[0], -1, 0, 1'b1, 1'b1);

      // Reset asserted in MAC of row 1.
      dc_before = done_cnt[0];
      @(negedge clk);
      start_a[0] = 1'b1;
      q_vec_a[0] = tbl[0].q;
      @(negedge clk);
      start_a[0]   = 1'b0;
      k_row_a[0]   = tbl[0].rows[0];
      k_valid_a[0] = 1'b1;
      s_ready_a[0] = 1'b1;
      @(negedge clk);
      k_valid_a[0] = 1'b0;
      n = 0;
      while (!s_valid_a[0] && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("abort row0 score", int'($signed(score_a[0])), int'(tbl[0].exp[0]));
      @(negedge clk);
      k_row_a[0]   = tbl[0].rows[1];
      k_valid_a[0] = 1'b1;
      @(negedge clk);
      k_valid_a[0] = 1'b0;
      @(negedge clk);
      check("abort in mac busy", busy_a[0], 1);
      check("abort in mac s_valid", s_valid_a[0], 0);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      @(negedge clk);
      @(negedge clk);
      check("abort no done", done_cnt[0] - dc_before, 0);
      rst_n      = 1'b1;
      start_a[0] = 1'b1;
      q_vec_a[0] = tbl[0].q;
      @(negedge clk);
      start_a[0] = 1'b0;
      check("start at reset release ignored", busy_a[0], 0);
      run_job(0, tbl[0], -1, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
